// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the multicycle controller.
// `CTRL_MUL_EN adds the EXECUTEM state and the MUL ALU code.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH
`ifdef CTRL_MUL_EN
        , S_EXECUTEM
`endif
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
`ifdef CTRL_MUL_EN
    localparam logic [2:0] ALU_MUL = 3'b100;
`endif

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    typedef struct packed {
        logic [2:0] alu;
        logic       ok;
        logic       nowrite;
        logic       cv;
    } dp_dec_t;

    // Data-processing cmd decode: ALU op, legality, CMP, C/V update.
    function automatic dp_dec_t dp_decode(input logic [3:0] cmd);
        dp_dec_t d;
        d     = '0;
        d.alu = ALU_ADD;
        d.ok  = 1'b1;
        case (cmd)
            CMD_ADD: d.cv = 1'b1;
            CMD_SUB: begin
                d.alu = ALU_SUB;
                d.cv  = 1'b1;
            end
            CMD_AND: d.alu = ALU_AND;
            CMD_ORR: d.alu = ALU_ORR;
            CMD_CMP: begin
                d.alu     = ALU_SUB;
                d.nowrite = 1'b1;
                d.cv      = 1'b1;
            end
            default: d.ok = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/multicycle_controller_cond_check.sv
// cond_check: ARM condition evaluation against {N,Z,C,V}.
// Purely combinational; code 1111 never executes.
module cond_check
    import ctrl_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_condex
);
    logic w_n, w_z, w_c, w_v;

    assign w_n = i_flags[3];
    assign w_z = i_flags[2];
    assign w_c = i_flags[1];
    assign w_v = i_flags[0];

    // Map condition code to pass/fail.
    always_comb begin
        o_condex = 1'b0;
        case (i_cond)
            COND_EQ: o_condex = w_z;
            COND_NE: o_condex = ~w_z;
            COND_CS: o_condex = w_c;
            COND_CC: o_condex = ~w_c;
            COND_MI: o_condex = w_n;
            COND_PL: o_condex = ~w_n;
            COND_VS: o_condex = w_v;
            COND_VC: o_condex = ~w_v;
            COND_HI: o_condex = w_c & ~w_z;
            COND_LS: o_condex = ~w_c | w_z;
            COND_GE: o_condex = (w_n == w_v);
            COND_LT: o_condex = (w_n != w_v);
            COND_GT: o_condex = ~w_z & (w_n == w_v);
            COND_LE: o_condex = w_z | (w_n != w_v);
            COND_AL: o_condex = 1'b1;
            default: o_condex = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle ARM-subset control FSM.
// Optional `CTRL_MUL_EN adds the EXECUTEM multiply state.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 3,
    parameter int MAX_WAIT  = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:4]          Instr,
    input  logic [3:0]           ALUFlags,
    input  logic                 MemReady,
    output logic                 PCWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic                 MemWrite,
    output logic                 AdrSrc,
    output logic [1:0]           RegSrc,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ResultSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 BusErr,
    output logic                 Illegal
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_flags;
    logic [CW-1:0] r_wait;
    logic          r_buserr;
    logic [1:0]    w_op;
    logic [2:0]    w_alu;
    dp_dec_t       w_dec;
    logic          w_condex;
    logic          w_memwait;
    logic          w_exec;
    logic          w_flag_we;
    logic          w_cv_we;
    logic          w_dp_ill;
    logic          w_unused;

    assign w_op       = Instr[27:26];
    assign w_dec      = dp_decode(Instr[24:21]);
    assign ImmSrc     = w_op;
    assign RegSrc     = {w_op == OP_MEM, w_op == OP_BR};
    assign ALUControl = ALUCTRL_W'(w_alu);
    assign BusErr     = r_buserr;

`ifdef CTRL_MUL_EN
    logic w_mul;
    assign w_mul    = ~Instr[25] & (Instr[7:4] == 4'b1001);
    assign w_dp_ill = ~w_dec.ok & ~w_mul;
    assign w_exec   = (r_state == S_EXECUTER) |
                      (r_state == S_EXECUTEI) |
                      (r_state == S_EXECUTEM);
    assign w_unused = ^{Instr[19:16], Instr[11:8]};
`else
    assign w_dp_ill = ~w_dec.ok;
    assign w_exec   = (r_state == S_EXECUTER) |
                      (r_state == S_EXECUTEI);
    assign w_unused = ^{Instr[19:16], Instr[11:4]};
`endif

    assign w_cv_we   = ((r_state == S_EXECUTER) |
                        (r_state == S_EXECUTEI)) & w_dec.cv;
    assign w_flag_we = w_exec & Instr[20] & w_condex;
    assign w_memwait = ~MemReady & ((r_state == S_FETCH) |
                                    (r_state == S_MEMREAD) |
                                    (r_state == S_MEMWRITE));

    cond_check u_cond (
        .i_cond   (Instr[31:28]),
        .i_flags  (r_flags),
        .o_condex (w_condex)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    // Flags: N/Z on any S-execute, C/V only for ADD/SUB/CMP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags <= '0;
        end else if (w_flag_we) begin
            r_flags[3:2] <= ALUFlags[3:2];
            if (w_cv_we) r_flags[1:0] <= ALUFlags[1:0];
        end
    end

    // Memory wait counter with sticky timeout flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait   <= '0;
            r_buserr <= 1'b0;
        end else if (w_memwait) begin
            if (r_wait != CW'(MAX_WAIT)) r_wait <= r_wait + CW'(1);
            if (r_wait == CW'(MAX_WAIT - 1)) r_buserr <= 1'b1;
        end else begin
            r_wait <= '0;
        end
    end

    // Next state and Mealy datapath controls.
    always_comb begin
        w_next    = r_state;
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        w_alu     = ALU_ADD;
        Illegal   = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
                if (MemReady) w_next = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (w_op)
                    OP_MEM: w_next = S_MEMADR;
                    OP_DP: begin
                        Illegal = w_dp_ill;
                        if (Instr[25]) w_next = S_EXECUTEI;
`ifdef CTRL_MUL_EN
                        else if (w_mul) w_next = S_EXECUTEM;
`endif
                        else w_next = S_EXECUTER;
                    end
                    OP_BR: w_next = S_BRANCH;
                    default: begin
                        Illegal = 1'b1;
                        w_next  = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
                w_next  = Instr[20] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (MemReady) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = w_condex;
                w_next    = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = w_condex;
                if (MemReady) w_next = S_FETCH;
            end
            S_EXECUTER: begin
                w_alu  = w_dec.alu;
                w_next = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcB = 2'b01;
                w_alu   = w_dec.alu;
                w_next  = S_ALUWB;
            end
`ifdef CTRL_MUL_EN
            S_EXECUTEM: begin
                w_alu  = ALU_MUL;
                w_next = S_ALUWB;
            end
`endif
            S_ALUWB: begin
                RegWrite = w_condex & ~w_dec.nowrite;
                w_next   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = w_condex;
                w_next    = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
        // A register write to R15 is a PC write.
        if (RegWrite && Instr[15:12] == 4'hF) PCWrite = 1'b1;
        if (!reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            Illegal  = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed checks of the control FSM.
// Second instance uses MAX_WAIT=2 for the bus-timeout case.
module tb_multicycle_controller;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemReady = 1'b1;
    logic [31:4] Instr = '0;
    logic [3:0]  ALUFlags = '0;

    logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc;
    logic [1:0] RegSrc, ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
    logic [2:0] ALUControl;
    logic       BusErr, Illegal;

    logic       b_PCWrite, b_IRWrite, b_RegWrite, b_MemWrite, b_AdrSrc;
    logic [1:0] b_RegSrc, b_ImmSrc, b_ALUSrcA, b_ALUSrcB, b_ResultSrc;
    logic [2:0] b_ALUControl;
    logic       b_BusErr, b_Illegal;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    multicycle_controller u_dut (
        .clk(clk), .reset(reset), .Instr(Instr),
        .ALUFlags(ALUFlags), .MemReady(MemReady),
        .PCWrite(PCWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .MemWrite(MemWrite),
        .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ImmSrc(ImmSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ALUControl(ALUControl),
        .BusErr(BusErr), .Illegal(Illegal)
    );

    multicycle_controller #(.MAX_WAIT(2)) u_dut2 (
        .clk(clk), .reset(reset), .Instr(Instr),
        .ALUFlags(ALUFlags), .MemReady(MemReady),
        .PCWrite(b_PCWrite), .IRWrite(b_IRWrite),
        .RegWrite(b_RegWrite), .MemWrite(b_MemWrite),
        .AdrSrc(b_AdrSrc), .RegSrc(b_RegSrc), .ImmSrc(b_ImmSrc),
        .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB),
        .ResultSrc(b_ResultSrc), .ALUControl(b_ALUControl),
        .BusErr(b_BusErr), .Illegal(b_Illegal)
    );

    wire [7:0] en  = {3'b0, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc};
    wire [7:0] sel = {2'b0, ALUSrcA, ALUSrcB, ResultSrc};
    wire [7:0] alu = {5'b0, ALUControl};
    wire [7:0] ill = {7'b0, Illegal};
    wire [7:0] be  = {7'b0, BusErr};
    wire [7:0] be2 = {7'b0, b_BusErr};

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [3:0] cond,
                                       input logic [1:0] op,
                                       input logic [5:0] funct,
                                       input logic [3:0] rd);
        return {cond, op, funct, 4'h2, rd, 12'h000};
    endfunction

    task automatic load(input logic [31:0] ins);
        logic [31:0] v;
        v     = ins;
        Instr = v[31:4];
        #1;
    endtask

    // One data-processing instruction from FETCH back to FETCH.
    task automatic run_dp(input string t, input logic [31:0] ins,
                          input logic [7:0] ealu, input logic [7:0] eill,
                          input logic [7:0] ewb);
        load(ins);
        chk({t, "_f_en"}, en, 8'h18);
        chk({t, "_f_sel"}, sel, 8'h1a);
        tick();
        chk({t, "_d_en"}, en, 8'h00);
        chk({t, "_d_ill"}, ill, eill);
        tick();
        chk({t, "_e_en"}, en, 8'h00);
        chk({t, "_e_alu"}, alu, ealu);
        chk({t, "_e_sel"}, sel, ins[25] ? 8'h04 : 8'h00);
        tick();
        chk({t, "_w_en"}, en, ewb);
        chk({t, "_w_ill"}, ill, 8'h00);
        tick();
    endtask

    initial begin
        tick();
        tick();
        chk("rst_en", en, 8'h00);
        chk("rst_ill", ill, 8'h00);
        chk("rst_buserr", be, 8'h00);
        chk("rst_buserr2", be2, 8'h00);
        reset = 1'b1;

        run_dp("add", mk(4'he, 2'b00, 6'b001000, 4'h1), 8'h0, 8'h0, 8'h04);
        run_dp("subi", mk(4'he, 2'b00, 6'b100100, 4'h2), 8'h1, 8'h0, 8'h04);
        run_dp("and", mk(4'he, 2'b00, 6'b000000, 4'h3), 8'h2, 8'h0, 8'h04);
        run_dp("orr", mk(4'he, 2'b00, 6'b011000, 4'h3), 8'h3, 8'h0, 8'h04);

        ALUFlags = 4'b0100;
        run_dp("cmp", mk(4'he, 2'b00, 6'b010101, 4'h0), 8'h1, 8'h0, 8'h00);
        ALUFlags = 4'b0000;
        run_dp("addeq", mk(4'h0, 2'b00, 6'b001000, 4'h1), 8'h0, 8'h0, 8'h04);
        run_dp("addne", mk(4'h1, 2'b00, 6'b001000, 4'h1), 8'h0, 8'h0, 8'h00);
        run_dp("eor", mk(4'he, 2'b00, 6'b000010, 4'h1), 8'h0, 8'h1, 8'h04);
        run_dp("addpc", mk(4'he, 2'b00, 6'b001000, 4'hf), 8'h0, 8'h0, 8'h14);

        load(mk(4'he, 2'b01, 6'b011001, 4'h1));
        chk("ldr_f_en", en, 8'h18);
        tick();
        chk("ldr_d_en", en, 8'h00);
        tick();
        chk("ldr_ma_sel", sel, 8'h04);
        chk("ldr_ma_en", en, 8'h00);
        MemReady = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("ldr_mr_wait_en", en, 8'h01);
            tick();
        end
        MemReady = 1'b1;
        #1;
        chk("ldr_mr_rdy_en", en, 8'h01);
        tick();
        chk("ldr_wb_en", en, 8'h04);
        chk("ldr_wb_sel", sel, 8'h01);
        tick();
        chk("ldr_next_f_en", en, 8'h18);
        chk("ldr_buserr_15", be, 8'h00);
        chk("ldr_buserr_2", be2, 8'h01);

        load(mk(4'he, 2'b01, 6'b011000, 4'h1));
        tick();
        tick();
        tick();
        chk("str_mw_en", en, 8'h03);
        tick();
        chk("str_next_f_en", en, 8'h18);

        load(mk(4'he, 2'b10, 6'b000000, 4'h0));
        tick();
        chk("b_d_en", en, 8'h00);
        tick();
        chk("b_br_en", en, 8'h10);
        chk("b_br_sel", sel, 8'h06);
        tick();
        chk("b_next_f_en", en, 8'h18);

        load(mk(4'hf, 2'b10, 6'b000000, 4'h0));
        tick();
        tick();
        chk("bnv_br_en", en, 8'h00);
        tick();

        load(mk(4'he, 2'b11, 6'b000000, 4'h1));
        chk("ill_f_en", en, 8'h18);
        tick();
        chk("ill_d_ill", ill, 8'h01);
        chk("ill_d_en", en, 8'h00);
        tick();
        chk("ill_next_f_en", en, 8'h18);
        chk("ill_next_ill", ill, 8'h00);
        chk("buserr2_sticky", be2, 8'h01);

        load(mk(4'he, 2'b01, 6'b011000, 4'h1));
        tick();
        tick();
        MemReady = 1'b0;
        tick();
        chk("rst_mw_before", en, 8'h03);
        reset = 1'b0;
        #1;
        chk("rst_mw_drop", en, 8'h00);
        tick();
        chk("rst_buserr2_clr", be2, 8'h00);
        MemReady = 1'b1;
        reset = 1'b1;
        #1;
        chk("rst_after_f_en", en, 8'h18);
        chk("rst_after_f_sel", sel, 8'h1a);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
